// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// A request is issued by holding data_req high with address, size, strobes and
// write data stable. The memory accepts it in the cycle data_addr_ok is high.
// Completion comes from data_data_ok: read data for a load, write acknowledge
// for a store. It may arrive in the same cycle as data_addr_ok or later.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [DATA_W-1:0]     data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: holds one instruction from EX and runs the data-memory
// request/response handshake for loads and stores. It formats byte strobes and
// replicated store data, and releases the instruction to WB only after its
// memory access has completed.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   - misaligned half/word accesses raise mem_align_err and issue no request
//   undefined - mem_align_err is 0; misaligned accesses are issued with low address bits cleared
//
// Pipeline handshake: EX hands over an instruction on a clock edge where
// ex_valid & mem_allowin. The stage hands its instruction to WB on an edge
// where mem_valid & mem_ready_go & wb_allowin. Both transfers may occur on the
// same edge, so there is no bubble between instructions.
//
// mem_state exposes the FSM state for debug: 0 IDLE, 1 REQ, 2 WAIT, 3 DONE.
module mem_access_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // From EX
    input  logic                ex_valid,
    input  logic [ADDR_W-1:0]   ex_alu_result,
    input  logic [DATA_W-1:0]   ex_store_data,
    input  logic                ex_mem_re,
    input  logic                ex_mem_we,
    input  logic [1:0]          ex_mem_size,
    // Pipeline control
    input  logic                wb_allowin,
    output logic                mem_allowin,
    output logic                mem_valid,
    output logic                mem_ready_go,
    // Results toward the MEM->WB register
    output logic [ADDR_W-1:0]   mem_alu_result,
    output logic [DATA_W-1:0]   mem_dram_rdata,
    output logic                mem_align_err,
    // Debug view of the FSM
    output logic [1:0]          mem_state,
    // Data-memory bus
    mem_access_stage_if.master  data_bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic                valid_q;
    logic [ADDR_W-1:0]   alu_q;
    logic [DATA_W-1:0]   sdata_q;
    logic                re_q;
    logic                we_q;
    logic [1:0]          size_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                align_err;

    logic                accept;
    logic                leave;
    logic                mem_op_q;
    logic                ex_mem_op;
    logic                ex_misaligned;
    logic                capture;

    logic [ADDR_W-1:0]   issue_addr;
    logic [DATA_W/8-1:0] issue_strb;
    logic [DATA_W-1:0]   issue_wdata;

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    assign mem_op_q  = re_q | we_q;
    assign ex_mem_op = ex_mem_re | ex_mem_we;

    // Non-memory ops and rejected misaligned ops are complete as soon as they
    // are held; memory ops wait for the bus to finish.
    assign mem_ready_go = valid_q & ((state_q == S_DONE) | ~mem_op_q | align_err);
    assign mem_allowin  = ~valid_q | (mem_ready_go & wb_allowin);
    assign accept       = ex_valid & mem_allowin;
    assign leave        = valid_q & mem_ready_go & wb_allowin;

`ifdef MEM_ALIGN_CHECK_EN
    logic align_err_q;

    // Decide at acceptance whether the incoming access is misaligned; size 3 is a word.
    always_comb begin
        ex_misaligned = 1'b0;
        if (ex_mem_size == 2'd1) begin
            ex_misaligned = ex_alu_result[0];
        end else if (ex_mem_size != 2'd0) begin
            ex_misaligned = |ex_alu_result[1:0];
        end
    end

    // Alignment error flag lives with the held instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_err_q <= 1'b0;
        end else if (accept) begin
            align_err_q <= ex_mem_op & ex_misaligned;
        end
    end

    assign align_err = align_err_q;
`else
    // Without the check every memory op goes to the bus, with its address aligned down.
    assign ex_misaligned = 1'b0;
    assign align_err     = 1'b0;
`endif

    // Instruction register: latch EX fields on acceptance, drop valid when the op leaves empty-handed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            sdata_q <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
        end else if (accept) begin
            valid_q <= 1'b1;
            alu_q   <= ex_alu_result;
            sdata_q <= ex_store_data;
            re_q    <= ex_mem_re;
            we_q    <= ex_mem_we;
            size_q  <= ex_mem_size;
        end else if (leave) begin
            valid_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Bus FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and load-data capture. A data_ok seen in IDLE or DONE is a
    // stale response and is ignored; in REQ it only counts with addr_ok.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            S_REQ: begin
                if (data_bus.data_addr_ok) begin
                    if (data_bus.data_data_ok) begin
                        state_d = S_DONE;
                        capture = re_q;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (data_bus.data_data_ok) begin
                    state_d = S_DONE;
                    capture = re_q;
                end
            end
            default: begin
            end
        endcase
        // A new instruction replaces the old one on the same edge it leaves.
        if (accept) begin
            state_d = (ex_mem_op & ~ex_misaligned) ? S_REQ : S_IDLE;
        end else if (leave) begin
            state_d = S_IDLE;
        end
    end

    // Raw load word; held through any WB stall because it only changes on capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (capture) begin
            rdata_q <= data_bus.data_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Request formatting (all from held registers, so stable while in REQ)
    // ------------------------------------------------------------------

    // Address aligned down to the access size; strobes and replicated write data by lane.
    always_comb begin
        issue_addr  = alu_q;
        issue_strb  = 4'b1111;
        issue_wdata = sdata_q;
        case (size_q)
            2'd0: begin
                issue_strb  = 4'b0001 << alu_q[1:0];
                issue_wdata = {4{sdata_q[7:0]}};
            end
            2'd1: begin
                issue_addr  = {alu_q[ADDR_W-1:1], 1'b0};
                issue_strb  = alu_q[1] ? 4'b1100 : 4'b0011;
                issue_wdata = {2{sdata_q[15:0]}};
            end
            default: begin
                issue_addr  = {alu_q[ADDR_W-1:2], 2'b00};
                issue_strb  = 4'b1111;
                issue_wdata = sdata_q;
            end
        endcase
        if (!we_q) begin
            issue_strb = '0;
        end
    end

    assign data_bus.data_req   = (state_q == S_REQ);
    assign data_bus.data_wr    = we_q;
    assign data_bus.data_size  = size_q;
    assign data_bus.data_addr  = issue_addr;
    assign data_bus.data_wstrb = issue_strb;
    assign data_bus.data_wdata = issue_wdata;

    assign mem_valid      = valid_q;
    assign mem_alu_result = alu_q;
    assign mem_dram_rdata = rdata_q;
    assign mem_align_err  = align_err;
    assign mem_state      = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed scenarios plus a randomized mix of
// loads, stores and ALU ops, against a small arithmetic model of the bus format.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_re;
    logic        ex_mem_we;
    logic [1:0]  ex_mem_size;
    logic        wb_allowin;
    logic        mem_allowin;
    logic        mem_valid;
    logic        mem_ready_go;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_dram_rdata;
    logic        mem_align_err;
    logic [1:0]  mem_state;

    mem_access_stage_if bus ();

    mem_access_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_alu_result  (ex_alu_result),
        .ex_store_data  (ex_store_data),
        .ex_mem_re      (ex_mem_re),
        .ex_mem_we      (ex_mem_we),
        .ex_mem_size    (ex_mem_size),
        .wb_allowin     (wb_allowin),
        .mem_allowin    (mem_allowin),
        .mem_valid      (mem_valid),
        .mem_ready_go   (mem_ready_go),
        .mem_alu_result (mem_alu_result),
        .mem_dram_rdata (mem_dram_rdata),
        .mem_align_err  (mem_align_err),
        .mem_state      (mem_state),
        .data_bus       (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_load = 32'h0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic void model_bus(input logic [31:0] addr, input logic [31:0] d,
                                      input logic [1:0] sz, input logic we,
                                      output logic [31:0] a, output logic [3:0] s,
                                      output logic [31:0] w);
        int b = nbytes(sz);
        a = addr - (addr % b);
        s = we ? 4'(((1 << b) - 1) << (a % 4)) : 4'd0;
        if (b == 1)      w = d[7:0] * 32'h0101_0101;
        else if (b == 2) w = d[15:0] * 32'h0001_0001;
        else             w = d;
    endfunction

    function automatic logic model_rejects(input logic [31:0] addr, input logic [1:0] sz);
        logic m = (addr % nbytes(sz)) != 0;
`ifdef MEM_ALIGN_CHECK_EN
        return m;
`else
        return m & 1'b0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] alu, input logic [31:0] sd,
                         input logic re, input logic we, input logic [1:0] sz);
        int n = 0;
        ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd;
        ex_mem_re = re; ex_mem_we = we; ex_mem_size = sz;
        #1;
        while (!mem_allowin && n < 50) begin
            tick();
            n++;
        end
        n_tests++;
        if (mem_allowin !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_allowin: got %b expected 1", mem_allowin);
        end
        @(posedge clk);
        #1;
        ex_valid = 1'b0; ex_alu_result = $urandom; ex_store_data = $urandom;
        ex_mem_re = 1'b0; ex_mem_we = 1'b0; ex_mem_size = 2'($urandom_range(0, 3));
    endtask

    // Plays the memory side for the op just accepted, then holds DONE for
    // 'stall' cycles with wb_allowin low. Returns with wb_allowin high.
    task automatic serve(input logic [31:0] alu, input logic [31:0] sd, input logic re,
                         input logic we, input logic [1:0] sz,
                         input int a_dly, input int d_dly, input int stall);
        logic [31:0] ea, ew, rd, exp;
        logic [3:0]  es;
        model_bus(alu, sd, sz, we, ea, es, ew);
        rd = $urandom;
        for (int i = 0; i < a_dly; i++) begin
            #1;
            n_tests++;
            if (bus.data_req !== 1'b1 || mem_ready_go !== 1'b0) begin
                n_fail++;
                $display("FAIL req_hold: req=%b ready_go=%b expected 1/0", bus.data_req, mem_ready_go);
            end
            n_tests++;
            if (bus.data_addr !== ea) begin
                n_fail++;
                $display("FAIL addr_stable: got %h expected %h", bus.data_addr, ea);
            end
            tick();
        end
        #1;
        n_tests++;
        if (bus.data_req !== 1'b1) begin
            n_fail++; $display("FAIL data_req: got %b expected 1", bus.data_req);
        end
        n_tests++;
        if (bus.data_addr !== ea) begin
            n_fail++; $display("FAIL data_addr: got %h expected %h", bus.data_addr, ea);
        end
        n_tests++;
        if (bus.data_wstrb !== es) begin
            n_fail++; $display("FAIL data_wstrb: got %b expected %b", bus.data_wstrb, es);
        end
        n_tests++;
        if (bus.data_wr !== we || bus.data_size !== sz) begin
            n_fail++;
            $display("FAIL wr_size: got %b/%0d expected %b/%0d", bus.data_wr, bus.data_size, we, sz);
        end
        if (we) begin
            n_tests++;
            if (bus.data_wdata !== ew) begin
                n_fail++; $display("FAIL data_wdata: got %h expected %h", bus.data_wdata, ew);
            end
        end
        bus.data_addr_ok = 1'b1;
        if (d_dly == 0) begin
            bus.data_data_ok = 1'b1;
            bus.data_rdata   = rd;
        end
        tick();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
        if (d_dly > 0) begin
            for (int i = 0; i < d_dly - 1; i++) begin
                n_tests++;
                if (bus.data_req !== 1'b0 || mem_ready_go !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wait_state: req=%b ready_go=%b expected 0/0", bus.data_req, mem_ready_go);
                end
                tick();
            end
            bus.data_data_ok = 1'b1;
            bus.data_rdata   = rd;
            tick();
            bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
        end
        if (re) last_load = rd;
        exp_q.push_back(last_load);
        for (int s = 0; s < stall; s++) begin
            wb_allowin = 1'b0;
            #1;
            n_tests++;
            if (mem_ready_go !== 1'b1 || mem_dram_rdata !== last_load || mem_alu_result !== alu) begin
                n_fail++;
                $display("FAIL done_hold: ready_go=%b rdata=%h alu=%h expected 1/%h/%h",
                         mem_ready_go, mem_dram_rdata, mem_alu_result, last_load, alu);
            end
            tick();
        end
        wb_allowin = 1'b1;
        #1;
        exp = exp_q.pop_front();
        n_tests++;
        if (mem_ready_go !== 1'b1 || mem_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL done_ready: ready_go=%b valid=%b expected 1/1", mem_ready_go, mem_valid);
        end
        n_tests++;
        if (mem_dram_rdata !== exp) begin
            n_fail++; $display("FAIL dram_rdata: got %h expected %h", mem_dram_rdata, exp);
        end
    endtask

    task automatic drain();
        tick();
        n_tests++;
        if (mem_valid !== 1'b0 || bus.data_req !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: valid=%b req=%b expected 0/0", mem_valid, bus.data_req);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0;
        ex_mem_re = 1'b0; ex_mem_we = 1'b0; ex_mem_size = 2'd0; wb_allowin = 1'b1;
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
        tick(); tick();
        n_tests++;
        if (mem_valid !== 1'b0 || mem_ready_go !== 1'b0 || mem_allowin !== 1'b1 || mem_align_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid=%b ready_go=%b allowin=%b err=%b expected 0/0/1/0",
                     mem_valid, mem_ready_go, mem_allowin, mem_align_err);
        end
        n_tests++;
        if (mem_alu_result !== 32'h0 || mem_dram_rdata !== 32'h0 || mem_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_regs: alu=%h rdata=%h state=%0d expected 0/0/0",
                     mem_alu_result, mem_dram_rdata, mem_state);
        end
        n_tests++;
        if (bus.data_req !== 1'b0 || bus.data_wr !== 1'b0 || bus.data_addr !== 32'h0 ||
            bus.data_wstrb !== 4'h0 || bus.data_wdata !== 32'h0 || bus.data_size !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_bus: req=%b wr=%b addr=%h strb=%b wdata=%h expected all 0",
                     bus.data_req, bus.data_wr, bus.data_addr, bus.data_wstrb, bus.data_wdata);
        end
        rst = 1'b0;
        tick();
        last_load = 32'h0;
    endtask

    task automatic test_non_mem();
        issue(32'h1234, 32'h0, 1'b0, 1'b0, 2'd2);
        n_tests++;
        if (mem_valid !== 1'b1 || mem_ready_go !== 1'b1 || mem_alu_result !== 32'h1234 || bus.data_req !== 1'b0) begin
            n_fail++;
            $display("FAIL non_mem: valid=%b ready_go=%b alu=%h req=%b expected 1/1/1234/0",
                     mem_valid, mem_ready_go, mem_alu_result, bus.data_req);
        end
        drain();
    endtask

    task automatic test_load();
        issue(32'h1000, 32'h0, 1'b1, 1'b0, 2'd2);
        serve(32'h1000, 32'h0, 1'b1, 1'b0, 2'd2, 2, 3, 0);
        drain();
    endtask

    task automatic test_stores();
        issue(32'h1003, 32'hA5, 1'b0, 1'b1, 2'd0);
        #1;
        n_tests++;
        if (bus.data_wstrb !== 4'b1000 || bus.data_wdata !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL store_byte: strb=%b wdata=%h expected 1000/a5a5a5a5", bus.data_wstrb, bus.data_wdata);
        end
        serve(32'h1003, 32'hA5, 1'b0, 1'b1, 2'd0, 1, 1, 0);
        issue(32'h1002, 32'hBEEF, 1'b0, 1'b1, 2'd1);
        #1;
        n_tests++;
        if (bus.data_wstrb !== 4'b1100 || bus.data_wdata !== 32'hBEEF_BEEF) begin
            n_fail++;
            $display("FAIL store_half: strb=%b wdata=%h expected 1100/beefbeef", bus.data_wstrb, bus.data_wdata);
        end
        serve(32'h1002, 32'hBEEF, 1'b0, 1'b1, 2'd1, 0, 2, 1);
        drain();
    endtask

    task automatic test_back_to_back();
        issue(32'h2000, 32'h0, 1'b1, 1'b0, 2'd2);
        serve(32'h2000, 32'h0, 1'b1, 1'b0, 2'd2, 0, 0, 3);
        issue(32'h2004, 32'h0, 1'b1, 1'b0, 2'd2);
        n_tests++;
        if (mem_valid !== 1'b1 || bus.data_req !== 1'b1 || mem_alu_result !== 32'h2004) begin
            n_fail++;
            $display("FAIL back_to_back: valid=%b req=%b alu=%h expected 1/1/2004",
                     mem_valid, bus.data_req, mem_alu_result);
        end
        serve(32'h2004, 32'h0, 1'b1, 1'b0, 2'd2, 0, 1, 0);
        drain();
    endtask

    task automatic test_reset_mid();
        issue(32'h3000, 32'h0, 1'b1, 1'b0, 2'd2);
        bus.data_addr_ok = 1'b1;
        tick();
        bus.data_addr_ok = 1'b0;
        #1;
        n_tests++;
        if (mem_valid !== 1'b1 || bus.data_req !== 1'b0 || mem_ready_go !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_entry: valid=%b req=%b ready_go=%b expected 1/0/0",
                     mem_valid, bus.data_req, mem_ready_go);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (mem_valid !== 1'b0 || bus.data_req !== 1'b0 || mem_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b req=%b state=%0d expected 0/0/0", mem_valid, bus.data_req, mem_state);
        end
        tick();
        rst = 1'b0;
        last_load = 32'h0;
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'h5555_AAAA;
        tick();
        bus.data_data_ok = 1'b0;
        n_tests++;
        if (mem_valid !== 1'b0 || bus.data_req !== 1'b0 || mem_state !== 2'd0 || mem_dram_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL stray_data_ok: valid=%b req=%b state=%0d rdata=%h expected 0/0/0/0",
                     mem_valid, bus.data_req, mem_state, mem_dram_rdata);
        end
        issue(32'h3010, 32'h0, 1'b1, 1'b0, 2'd2);
        serve(32'h3010, 32'h0, 1'b1, 1'b0, 2'd2, 1, 0, 0);
        drain();
    endtask

    task automatic test_align();
        issue(32'h1002, 32'h0, 1'b1, 1'b0, 2'd2);
`ifdef MEM_ALIGN_CHECK_EN
        n_tests++;
        if (mem_align_err !== 1'b1 || bus.data_req !== 1'b0 || mem_ready_go !== 1'b1) begin
            n_fail++;
            $display("FAIL align_reject: err=%b req=%b ready_go=%b expected 1/0/1",
                     mem_align_err, bus.data_req, mem_ready_go);
        end
`else
        #1;
        n_tests++;
        if (mem_align_err !== 1'b0 || bus.data_addr !== 32'h1000) begin
            n_fail++;
            $display("FAIL align_mask: err=%b addr=%h expected 0/00001000", mem_align_err, bus.data_addr);
        end
        serve(32'h1002, 32'h0, 1'b1, 1'b0, 2'd2, 0, 1, 0);
`endif
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            int          kind = $urandom_range(0, 2);
            logic [31:0] a    = $urandom;
            logic [31:0] d    = $urandom;
            logic [1:0]  sz   = 2'($urandom_range(0, 3));
            logic        re   = (kind == 1);
            logic        we   = (kind == 2);
            logic        rej  = (re | we) & model_rejects(a, sz);
            issue(a, d, re, we, sz);
            if (!(re | we) || rej) begin
                n_tests++;
                if (mem_ready_go !== 1'b1 || bus.data_req !== 1'b0 || mem_align_err !== rej ||
                    mem_alu_result !== a || mem_dram_rdata !== last_load) begin
                    n_fail++;
                    $display("FAIL rand_nomem: ready_go=%b req=%b err=%b alu=%h rdata=%h expected 1/0/%b/%h/%h",
                             mem_ready_go, bus.data_req, mem_align_err, mem_alu_result, mem_dram_rdata,
                             rej, a, last_load);
                end
            end else begin
                serve(a, d, re, we, sz, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end
            if ($urandom_range(0, 1) == 0) drain();
        end
        drain();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_non_mem();
        test_load();
        test_stores();
        test_back_to_back();
        test_reset_mid();
        test_align();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
